// File: rtl/threewire_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : threewire_arbiter_if
// Brief    : Client request/grant bundle plus threewire master command path.
// Revision : 1.0
// ============================================================================
interface threewire_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_BITS = 9,
    parameter int DATA_BITS = 16
);
    logic [NUM_REQ-1:0]           in_req;
    logic [NUM_REQ-1:0]           in_req_mode_wr;
    logic [NUM_REQ*ADDR_BITS-1:0] in_req_addr;
    logic [NUM_REQ*DATA_BITS-1:0] in_req_wr_data;
    logic [NUM_REQ-1:0]           out_gnt;
    logic [NUM_REQ-1:0]           out_done;
    logic [DATA_BITS-1:0]         out_rd_data;
    logic                         out_error;
    logic                         out_busy;
    logic                         out_tw_start;
    logic                         out_tw_mode_wr;
    logic [ADDR_BITS-1:0]         out_tw_addr;
    logic [DATA_BITS-1:0]         out_tw_wr_data;
    logic [DATA_BITS-1:0]         in_tw_rd_data;
    logic                         in_tw_in_progress;

    // Arbiter side.
    modport slave (
        input  in_req, in_req_mode_wr, in_req_addr, in_req_wr_data,
               in_tw_rd_data, in_tw_in_progress,
        output out_gnt, out_done, out_rd_data, out_error, out_busy,
               out_tw_start, out_tw_mode_wr, out_tw_addr, out_tw_wr_data
    );

    // Clients and threewire master side.
    modport master (
        output in_req, in_req_mode_wr, in_req_addr, in_req_wr_data,
               in_tw_rd_data, in_tw_in_progress,
        input  out_gnt, out_done, out_rd_data, out_error, out_busy,
               out_tw_start, out_tw_mode_wr, out_tw_addr, out_tw_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/threewire_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : threewire_arbiter
// Brief    : Round-robin arbiter/sequencer sharing one threewire bus master.
// Revision : 1.0
// ============================================================================
module threewire_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_BITS      = 9,
    parameter int DATA_BITS      = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               in_clk,
    input  logic               in_rst,
    threewire_arbiter_if.slave bus
);
    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_RESET = c_PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_GNT_ONE   = NUM_REQ'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_XFER  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [c_PTR_W-1:0]   r_owner;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_abort;
    logic                 r_tw_start;
    logic                 r_tw_mode_wr;
    logic [ADDR_BITS-1:0] r_tw_addr;
    logic [DATA_BITS-1:0] r_tw_wr_data;
    logic [DATA_BITS-1:0] r_rd_data;

    logic                 w_found;
    logic [c_PTR_W-1:0]   w_winner;
    int                   w_idx;
    logic                 w_timeout;
    logic                 w_grant;

    // First asserted requester strictly after the last owner, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && bus.in_req[c_PTR_W'(w_idx)]) begin
                w_found  = 1'b1;
                w_winner = c_PTR_W'(w_idx);
            end
        end
    end

    // A master still busy from before an arbiter reset must not be restarted.
    assign w_grant   = (r_state == c_ST_IDLE) && w_found && !bus.in_tw_in_progress;
    assign w_timeout = (r_cnt == c_CNT_LAST);

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant) w_next_state = c_ST_START;
            end
            c_ST_START: begin
                if (bus.in_tw_in_progress) w_next_state = c_ST_XFER;
                else if (w_timeout)        w_next_state = c_ST_DONE;
            end
            c_ST_XFER: begin
                if (!bus.in_tw_in_progress) w_next_state = c_ST_DONE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_gnt        <= '0;
            r_owner      <= '0;
            r_ptr        <= c_PTR_RESET;
            r_cnt        <= '0;
            r_abort      <= 1'b0;
            r_tw_start   <= 1'b0;
            r_tw_mode_wr <= 1'b0;
            r_tw_addr    <= '0;
            r_tw_wr_data <= '0;
            r_rd_data    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant) begin
                        r_gnt        <= c_GNT_ONE << w_winner;
                        r_owner      <= w_winner;
                        r_tw_start   <= 1'b1;
                        r_tw_mode_wr <= bus.in_req_mode_wr[w_winner];
                        r_tw_addr    <= bus.in_req_addr[w_winner*ADDR_BITS +: ADDR_BITS];
                        r_tw_wr_data <= bus.in_req_wr_data[w_winner*DATA_BITS +: DATA_BITS];
                    end
                end
                c_ST_START: begin
                    if (bus.in_tw_in_progress) begin
                        r_tw_start <= 1'b0;
                    end else if (w_timeout) begin
                        r_tw_start <= 1'b0;
                        r_abort    <= 1'b1;
                        r_rd_data  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_XFER: begin
                    if (!bus.in_tw_in_progress && !r_tw_mode_wr) begin
                        r_rd_data <= bus.in_tw_rd_data;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_ptr   <= r_owner;
                    r_cnt   <= '0;
                    r_abort <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.out_gnt        = r_gnt;
        bus.out_done       = (r_state == c_ST_DONE) ? r_gnt : '0;
        bus.out_error      = (r_state == c_ST_DONE) && r_abort;
        bus.out_busy       = (r_state != c_ST_IDLE);
        bus.out_rd_data    = r_rd_data;
        bus.out_tw_start   = r_tw_start;
        bus.out_tw_mode_wr = r_tw_mode_wr;
        bus.out_tw_addr    = r_tw_addr;
        bus.out_tw_wr_data = r_tw_wr_data;
    end
endmodule
`default_nettype wire

// File: tb/tb_threewire_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_threewire_arbiter
// Brief    : Directed plus randomized bench with a transaction-level reference.
// Revision : 1.0
// ============================================================================
module tb_threewire_arbiter;
    localparam int NUM_REQ        = 4;
    localparam int ADDR_BITS      = 9;
    localparam int DATA_BITS      = 16;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int AW_ALL         = NUM_REQ * ADDR_BITS;
    localparam int DW_ALL         = NUM_REQ * DATA_BITS;
    localparam logic [NUM_REQ-1:0] c_one = NUM_REQ'(1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    threewire_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) bus ();

    threewire_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_BITS(ADDR_BITS),
        .DATA_BITS(DATA_BITS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .in_clk(clk),
        .in_rst(rst_n),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int drop_mode = 0;   // 0: drop on done, 1: hold, 2: random
    bit rand_mode = 0, force_dead = 0, s_hold = 0, fixed_rd = 1;
    logic [DATA_BITS-1:0] rd_fixed = 16'h003D;
    bit s_busy = 0, s_armed = 0, s_dead = 0;
    int s_delay = 0, s_len = 0;
    logic                 cap_mode = 1'b0;
    logic [ADDR_BITS-1:0] cap_addr = '0;
    logic [DATA_BITS-1:0] cap_data = '0;
    int done_log[$];
    int gnt_log[$];

    // Reference: one transaction at a time, owner chosen round-robin after the last owner.
    int                   m_owner = -1;
    int                   m_last  = NUM_REQ - 1;
    int                   m_wait  = 0;
    int                   m_c     = 0;
    bit                   m_start = 0, m_xfer = 0, m_done = 0, m_abort = 0;
    logic                 m_mode  = 1'b0;
    logic [ADDR_BITS-1:0] m_addr  = '0;
    logic [DATA_BITS-1:0] m_wdata = '0;
    logic [DATA_BITS-1:0] m_rd    = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_last = NUM_REQ - 1; m_wait = 0;
            m_start = 0; m_xfer = 0; m_done = 0; m_abort = 0;
            m_mode = 1'b0; m_addr = '0; m_wdata = '0; m_rd = '0;
        end else if (m_done) begin
            m_last = m_owner; m_owner = -1; m_done = 0; m_abort = 0;
        end else if (m_start) begin
            if (bus.in_tw_in_progress) begin
                m_start = 0; m_xfer = 1;
            end else if (m_wait == TIMEOUT_CYCLES - 1) begin
                m_start = 0; m_abort = 1; m_done = 1; m_rd = '0;
            end else begin
                m_wait++;
            end
        end else if (m_xfer) begin
            if (!bus.in_tw_in_progress) begin
                m_xfer = 0; m_done = 1;
                if (!m_mode) m_rd = bus.in_tw_rd_data;
            end
        end else if (bus.in_req != '0 && !bus.in_tw_in_progress) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                m_c = (m_last + k) % NUM_REQ;
                if (bus.in_req[m_c]) begin
                    m_owner = m_c;
                    break;
                end
            end
            m_start = 1; m_wait = 0;
            m_mode  = bus.in_req_mode_wr[m_owner];
            m_addr  = bus.in_req_addr[m_owner*ADDR_BITS +: ADDR_BITS];
            m_wdata = bus.in_req_wr_data[m_owner*DATA_BITS +: DATA_BITS];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expire(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    logic [NUM_REQ-1:0] e_gnt;
    logic [63:0]        e_vec, a_vec;
    always @(negedge clk) begin
        e_gnt = (m_owner >= 0) ? (c_one << m_owner) : '0;
        e_vec = 64'({e_gnt, e_gnt & {NUM_REQ{m_done}}, m_rd, m_done && m_abort,
                     m_owner >= 0, m_start, m_mode, m_addr, m_wdata});
        a_vec = 64'({bus.out_gnt, bus.out_done, bus.out_rd_data, bus.out_error,
                     bus.out_busy, bus.out_tw_start, bus.out_tw_mode_wr,
                     bus.out_tw_addr, bus.out_tw_wr_data});
        chk("cycle_outputs", a_vec, e_vec);
    end

    function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) if (v[k]) return k;
        return -1;
    endfunction

    task automatic stub_step();
        if (s_busy) begin
            if (!s_hold) begin
                if (s_len == 0) begin
                    bus.in_tw_in_progress = 1'b0;
                    s_busy = 0;
                end else begin
                    s_len--;
                end
            end
        end else if (!bus.out_tw_start) begin
            s_armed = 0;
        end else begin
            if (!s_armed) begin
                s_armed = 1;
                s_delay = int'($urandom_range(0, 3));
                s_dead  = force_dead || (rand_mode && $urandom_range(0, 7) == 0);
            end
            if (!s_dead) begin
                if (s_delay == 0) begin
                    bus.in_tw_in_progress = 1'b1;
                    bus.in_tw_rd_data = fixed_rd ? rd_fixed : DATA_BITS'($urandom());
                    cap_mode = bus.out_tw_mode_wr;
                    cap_addr = bus.out_tw_addr;
                    cap_data = bus.out_tw_wr_data;
                    s_busy = 1; s_armed = 0;
                    s_len = int'($urandom_range(0, 3));
                end else begin
                    s_delay--;
                end
            end
        end
    endtask

    task automatic client_step();
        for (int k = 0; k < NUM_REQ; k++)
            if (!bus.in_req[k] && $urandom_range(0, 3) == 0) bus.in_req[k] = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
            bus.in_req_mode_wr = NUM_REQ'($urandom());
            bus.in_req_addr    = AW_ALL'({$urandom(), $urandom()});
            bus.in_req_wr_data = DW_ALL'({$urandom(), $urandom()});
        end
    endtask

    task automatic tick();
        logic [NUM_REQ-1:0] d_pre, g_pre;
        d_pre = bus.out_done;
        g_pre = bus.out_gnt;
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (d_pre[k]) begin
                done_log.push_back(k);
                if (drop_mode == 0 || (drop_mode == 2 && $urandom_range(0, 3) != 0))
                    bus.in_req[k] = 1'b0;
            end
        end
        if (g_pre == '0 && bus.out_gnt != '0) gnt_log.push_back(oh_idx(bus.out_gnt));
        stub_step();
        if (rand_mode) client_step();
    endtask

    task automatic wait_gnt(input string name);
        int n = 0;
        while (bus.out_gnt == '0 && n < 200) begin tick(); n++; end
        if (bus.out_gnt == '0) expire(name);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (bus.out_done == '0 && n < 200) begin tick(); n++; end
        if (bus.out_done == '0) expire(name);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((bus.in_req != '0 || bus.out_busy) && n < 600) begin tick(); n++; end
        if (bus.in_req != '0 || bus.out_busy) expire(name);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        bus.in_req = '0; bus.in_req_mode_wr = '0;
        bus.in_req_addr = '0; bus.in_req_wr_data = '0;
        bus.in_tw_rd_data = '0; bus.in_tw_in_progress = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_gnt", 64'(bus.out_gnt), 64'h0);
        chk("reset_busy", 64'(bus.out_busy), 64'h0);
        chk("reset_rd_data", 64'(bus.out_rd_data), 64'h0);
        rst_n = 1'b1;
        tick();

        // Single read from client 0.
        bus.in_req_mode_wr[0] = 1'b0;
        bus.in_req_addr[0 +: ADDR_BITS] = 9'h003;
        bus.in_req[0] = 1'b1;
        tick();
        chk("read_gnt_latency", 64'(bus.out_gnt), 64'h1);
        chk("read_start", 64'(bus.out_tw_start), 64'h1);
        chk("read_addr", 64'(bus.out_tw_addr), 64'h003);
        wait_done("read_done_wait");
        chk("read_done", 64'(bus.out_done), 64'h1);
        chk("read_data", 64'(bus.out_rd_data), 64'h003D);
        chk("read_error", 64'(bus.out_error), 64'h0);
        tick();
        wait_idle("read_idle");

        // Single write from client 2; inputs scrambled after grant.
        bus.in_req_mode_wr[2] = 1'b1;
        bus.in_req_addr[2*ADDR_BITS +: ADDR_BITS] = 9'h04E;
        bus.in_req_wr_data[2*DATA_BITS +: DATA_BITS] = 16'h0049;
        bus.in_req[2] = 1'b1;
        wait_gnt("write_gnt_wait");
        chk("write_gnt", 64'(bus.out_gnt), 64'h4);
        bus.in_req_mode_wr[2] = 1'b0;
        bus.in_req_addr[2*ADDR_BITS +: ADDR_BITS] = 9'h1FF;
        bus.in_req_wr_data[2*DATA_BITS +: DATA_BITS] = 16'hFFFF;
        wait_done("write_done_wait");
        chk("write_done", 64'(bus.out_done), 64'h4);
        chk("write_cap_mode", 64'(cap_mode), 64'h1);
        chk("write_cap_addr", 64'(cap_addr), 64'h04E);
        chk("write_cap_data", 64'(cap_data), 64'h0049);
        chk("write_rd_unchanged", 64'(bus.out_rd_data), 64'h003D);
        tick();
        wait_idle("write_idle");

        // Contention straight after reset: order 0,1,2,3.
        reset_pulse();
        done_log.delete();
        bus.in_req_mode_wr = '0;
        bus.in_req = '1;
        wait_idle("contend_idle");
        chk("contend_count", 64'(done_log.size()), 64'd4);
        for (int i = 0; i < done_log.size() && i < 4; i++)
            chk($sformatf("contend_order_%0d", i), 64'(done_log[i]), 64'(i));

        // Fairness: 1 and 3 held continuously.
        gnt_log.delete();
        drop_mode = 1;
        bus.in_req[1] = 1'b1;
        bus.in_req[3] = 1'b1;
        n = 0;
        while (gnt_log.size() < 8 && n < 400) begin tick(); n++; end
        if (gnt_log.size() < 8) expire("fair_gnt_wait");
        bus.in_req = '0;
        drop_mode = 0;
        wait_idle("fair_idle");
        for (int i = 0; i < gnt_log.size() && i < 8; i++)
            chk($sformatf("fair_order_%0d", i), 64'(gnt_log[i]), (i % 2 == 0) ? 64'd1 : 64'd3);

        // Timeout with a master that never answers.
        force_dead = 1;
        bus.in_req[1] = 1'b1;
        wait_gnt("tmo_gnt_wait");
        chk("tmo_gnt", 64'(bus.out_gnt), 64'h2);
        n = 0;
        while (bus.out_tw_start && n < 100) begin n++; tick(); end
        chk("tmo_start_cycles", 64'(n), 64'd16);
        chk("tmo_done", 64'(bus.out_done), 64'h2);
        chk("tmo_error", 64'(bus.out_error), 64'h1);
        chk("tmo_rd_zero", 64'(bus.out_rd_data), 64'h0);
        tick();
        chk("tmo_back_idle", 64'({bus.out_busy, bus.out_gnt}), 64'h0);
        force_dead = 0;
        wait_idle("tmo_idle");

        // Arbiter reset while the master is mid-transfer.
        s_hold = 1;
        bus.in_req[0] = 1'b1;
        wait_gnt("rst_gnt_wait");
        n = 0;
        while (!(bus.in_tw_in_progress && !bus.out_tw_start) && n < 50) begin tick(); n++; end
        if (!(bus.in_tw_in_progress && !bus.out_tw_start)) expire("rst_xfer_wait");
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", 64'({bus.out_gnt, bus.out_done, bus.out_busy, bus.out_error,
                                     bus.out_tw_start, bus.out_rd_data}), 64'h0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("rst_no_gnt_while_busy", 64'(bus.out_gnt), 64'h0);
        s_hold = 0;
        wait_gnt("rst_regrant_wait");
        chk("rst_regrant", 64'(bus.out_gnt), 64'h1);
        wait_done("rst_done_wait");
        tick();
        wait_idle("rst_idle");

        // Randomized traffic checked cycle by cycle against the reference.
        fixed_rd = 0;
        drop_mode = 2;
        rand_mode = 1;
        repeat (3000) tick();
        rand_mode = 0;
        drop_mode = 0;
        wait_idle("rand_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/threewire_arbiter.md
Name: threewire_arbiter

Overview:
Round-robin arbiter and sequencer that shares one threewire bus master between NUM_REQ client requesters. It latches the winning client's command and drives the master's start/mode/addr/wr_data inputs. It tracks the master's io-in-progress handshake, returns read data, and pulses a per-client done. It sits between the configuration clients and the threewire master, which is the only bus owner.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_BITS, 9, register address width
DATA_BITS, 16, data word width
TIMEOUT_CYCLES, 4096, max in_clk cycles in ST_START waiting for master in-progress before abort

Ports:
in_clk  input  1  system clock
in_rst  input  1  asynchronous reset, active-low (asserted when 0)
in_req  input  NUM_REQ  per-client request level; held until matching out_done
in_req_mode_wr  input  NUM_REQ  per-client direction, 1=write, 0=read
in_req_addr  input  NUM_REQ*ADDR_BITS  per-client address, client k at bits [k*ADDR_BITS +: ADDR_BITS]
in_req_wr_data  input  NUM_REQ*DATA_BITS  per-client write data, same packing
out_gnt  output  NUM_REQ  one-hot owner, high from grant through done cycle
out_done  output  NUM_REQ  one-cycle completion pulse to owner
out_rd_data  output  DATA_BITS  read data, valid in done cycle, held until next done
out_error  output  1  one-cycle pulse coincident with out_done on timeout abort
out_busy  output  1  high in any state except ST_IDLE
out_tw_start  output  1  to master start
out_tw_mode_wr  output  1  to master direction
out_tw_addr  output  ADDR_BITS  to master address
out_tw_wr_data  output  DATA_BITS  to master write data
in_tw_rd_data  input  DATA_BITS  from master read data
in_tw_in_progress  input  1  from master io-in-progress

Behaviour:
- Reset (in_rst=0, async): all outputs 0. State ST_IDLE. Round-robin pointer = NUM_REQ-1, so client 0 has first priority. Timeout counter 0.
- Registered FSM: ST_IDLE, ST_START, ST_XFER, ST_DONE.
- ST_IDLE: grant only if any in_req=1 AND in_tw_in_progress=0. This guards against a master left mid-transfer by an arbiter reset.
  - Winner = first asserted requester searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - Next edge: set out_gnt[winner] and out_tw_start=1. Latch winner's mode/addr/wr_data into out_tw_*. Go to ST_START.
  - Latency: req sampled high -> gnt/start high 1 cycle later.
- ST_START: hold out_tw_start=1 and the latched command; increment timeout counter.
  - in_tw_in_progress=1: drop out_tw_start next edge, go to ST_XFER.
  - Counter reaches TIMEOUT_CYCLES-1 without in-progress: drop out_tw_start, set abort flag, go to ST_DONE.
- ST_XFER: wait for in_tw_in_progress=0; no timeout. On 0, go to ST_DONE. If the command is a read, capture in_tw_rd_data into out_rd_data on the same edge.
- ST_DONE (exactly 1 cycle):
  - Pulse out_done[owner].
  - If aborted: pulse out_error and set out_rd_data=0.
  - Update pointer = owner; clear counter and abort flag.
  - Next edge: out_gnt=0, go to ST_IDLE.
- Write transactions leave out_rd_data unchanged.
- Client command inputs are ignored after grant; changing them mid-transaction has no effect.
- A requester deasserting in_req after grant does not cancel; the transaction completes and done still pulses.
- A requester holding in_req through done is treated as a new request, arbitrated with lowest priority, so no starvation.
- Minimum spacing between two grants: the done cycle plus 1 idle cycle.
- out_tw_addr, out_tw_mode_wr and out_tw_wr_data hold their last value in ST_IDLE.
- Timeout counter width: clog2(TIMEOUT_CYCLES); it saturates and never wraps.

Test Plan:
- Single read: in_req[0]=1, mode 0, addr 9'h003; slave returns 16'h003D -> out_gnt=0001, start held until in_progress, out_done[0] pulse, out_rd_data=16'h003D, out_error=0.
- Single write: in_req[2]=1, mode 1, addr 9'h04E, data 16'h0049 -> slave captures mode=1, addr 9'h04E, data 16'h0049; out_done[2] pulse; out_rd_data unchanged.
- Contention: all four requests asserted at the same cycle after reset -> grant order 0,1,2,3. After each done, requester drops req; exactly four out_done pulses in that order.
- Fairness: req1 and req3 held continuously -> grants alternate 1,3,1,3 for 8 transactions.
- Timeout: TIMEOUT_CYCLES=16, stub master never raises in_progress -> out_tw_start high 16 cycles, then out_done and out_error pulse together, out_rd_data=0, FSM back to ST_IDLE.
- Reset mid-transfer: assert in_rst=0 during ST_XFER while master still in progress -> all outputs 0 immediately. With req0 pending after release, no grant until in_tw_in_progress=0, then grant to client 0.
